// File: rtl/multi_mode_register.sv
// multi_mode_register: WIDTH-bit register with eight single-step modes
// (hold, load, shift, rotate, increment, clear). It also runs a multi-cycle
// shift/rotate of shamt steps, sequenced by an IDLE/RUN/DONE FSM.
module multi_mode_register #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   IN,
  input  logic               ser_in,
  input  logic               start,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   A,
  output logic               ser_out,
  output logic               carry,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_INC   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(1'b0);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Only the shift and rotate modes can be repeated as a multi-cycle command.
  function automatic logic is_multi(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) || (m == M_ROR);
  endfunction

  state_e               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           mode_q, mode_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 ser_out_q, ser_out_d;
  logic                 carry_q, carry_d;
  logic                 step_en_s;
  logic [2:0]           step_mode_s;
  logic [WIDTH:0]       inc_s;
  logic                 busy_s, done_s;

  // FSM state, step counter and latched command mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      mode_q  <= M_HOLD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic. It also decides whether this edge performs a datapath
  // step and which mode that step uses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    step_en_s   = 1'b0;
    step_mode_s = mode;
    case (state_q)
      S_IDLE: begin
        if (start && is_multi(mode)) begin
          mode_d = mode;
          if (shamt != CNT_ZERO) begin
            state_d = S_RUN;
            cnt_d   = shamt;
          end else begin
            state_d = S_DONE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          step_en_s   = 1'b1;
          step_mode_s = mode;
        end
      end
      S_RUN: begin
        step_en_s   = 1'b1;
        step_mode_s = mode_q;
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Decode the handshake outputs directly from the registered state so they
  // are glitch-free.
  always_comb begin
    busy_s = (state_q == S_RUN);
    done_s = (state_q == S_DONE);
  end

  // Datapath step. Flags keep their value unless the mode defines them.
  always_comb begin
    a_d       = a_q;
    ser_out_d = ser_out_q;
    carry_d   = carry_q;
    inc_s     = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
    if (step_en_s) begin
      case (step_mode_s)
        M_HOLD: begin
          a_d = a_q;
        end
        M_LOAD: begin
          a_d     = IN;
          carry_d = 1'b0;
        end
        M_SHL: begin
          a_d       = {a_q[WIDTH-2:0], ser_in};
          ser_out_d = a_q[WIDTH-1];
        end
        M_SHR: begin
          a_d       = {ser_in, a_q[WIDTH-1:1]};
          ser_out_d = a_q[0];
        end
        M_ROL: begin
          a_d       = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
          ser_out_d = a_q[WIDTH-1];
        end
        M_ROR: begin
          a_d       = {a_q[0], a_q[WIDTH-1:1]};
          ser_out_d = a_q[0];
        end
        M_INC: begin
          a_d     = inc_s[WIDTH-1:0];
          carry_d = inc_s[WIDTH];
        end
        M_CLEAR: begin
          a_d     = {WIDTH{1'b0}};
          carry_d = 1'b0;
        end
        default: begin
          a_d = a_q;
        end
      endcase
    end else begin
      a_d = a_q;
    end
  end

  // Register contents and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= {WIDTH{1'b0}};
      ser_out_q <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      a_q       <= a_d;
      ser_out_q <= ser_out_d;
      carry_q   <= carry_d;
    end
  end

  assign A       = a_q;
  assign ser_out = ser_out_q;
  assign carry   = carry_q;
  assign busy    = busy_s;
  assign done    = done_s;

endmodule

// File: tb/tb_multi_mode_register.sv
// Scoreboard bench for multi_mode_register (WIDTH=4, SHAMT_W=3). Each driven
// cycle pushes the model's expected outputs, which are popped and compared
// after the next rising edge.
module tb_multi_mode_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] mode;
  logic [3:0] IN;
  logic       ser_in;
  logic       start;
  logic [2:0] shamt;
  logic [3:0] A;
  logic       ser_out, carry, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] a;
    logic       so;
    logic       c;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: 0 idle, 1 run, 2 done.
  logic [3:0] m_a;
  logic       m_so, m_c;
  int         m_st;
  int         m_cnt;
  logic [2:0] m_mode;

  multi_mode_register #(.WIDTH(4), .SHAMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .IN(IN), .ser_in(ser_in),
    .start(start), .shamt(shamt), .A(A), .ser_out(ser_out),
    .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 4'h0; m_so = 1'b0; m_c = 1'b0; m_st = 0; m_cnt = 0; m_mode = 3'd0;
  endtask

  task automatic model_apply(input logic [2:0] m, input logic [3:0] d, input logic s);
    logic [4:0] sum;
    case (m)
      3'd1: begin m_a = d; m_c = 1'b0; end
      3'd2: begin m_so = m_a[3]; m_a = (m_a << 1) | {3'b000, s}; end
      3'd3: begin m_so = m_a[0]; m_a = (m_a >> 1) | {s, 3'b000}; end
      3'd4: begin m_so = m_a[3]; m_a = (m_a << 1) | (m_a >> 3); end
      3'd5: begin m_so = m_a[0]; m_a = (m_a >> 1) | (m_a << 3); end
      3'd6: begin sum = m_a + 5'd1; m_c = (m_a == 4'hF); m_a = sum[3:0]; end
      3'd7: begin m_a = 4'h0; m_c = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic [2:0] m, input logic [3:0] d, input logic s,
                            input logic st, input logic [2:0] sh);
    if (m_st == 0) begin
      if (st && m >= 3'd2 && m <= 3'd5) begin
        m_mode = m;
        if (sh == 3'd0) m_st = 2;
        else begin m_st = 1; m_cnt = sh; end
      end else model_apply(m, d, s);
    end else if (m_st == 1) begin
      model_apply(m_mode, d, s);
      if (m_cnt == 1) m_st = 2;
      m_cnt = m_cnt - 1;
    end else begin
      m_st = 0;
    end
  endtask

  // One clock: drive on the falling edge, push the expectation, compare after
  // the rising edge.
  task automatic cyc(input logic [2:0] m, input logic [3:0] d, input logic s,
                     input logic st, input logic [2:0] sh);
    exp_t e;
    exp_t g;
    @(negedge clk);
    mode = m; IN = d; ser_in = s; start = st; shamt = sh;
    model_edge(m, d, s, st, sh);
    e.a = m_a; e.so = m_so; e.c = m_c; e.b = (m_st == 1); e.d = (m_st == 2);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk_eq("A",       32'(A),       32'(g.a));
    chk_eq("ser_out", 32'(ser_out), 32'(g.so));
    chk_eq("carry",   32'(carry),   32'(g.c));
    chk_eq("busy",    32'(busy),    32'(g.b));
    chk_eq("done",    32'(done),    32'(g.d));
  endtask

  initial begin
    rst_n = 1'b1; mode = 3'd0; IN = 4'h0; ser_in = 1'b0; start = 1'b0; shamt = 3'd0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_A",    32'(A),       32'h0);
    chk_eq("rst_so",   32'(ser_out), 32'h0);
    chk_eq("rst_c",    32'(carry),   32'h0);
    chk_eq("rst_busy", 32'(busy),    32'h0);
    chk_eq("rst_done", 32'(done),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then load.
    cyc(3'd1, 4'b1011, 1'b0, 1'b0, 3'd0);
    chk_eq("tp_load", 32'(A), 32'b1011);

    // Multi-cycle ROL by 3; live inputs during RUN are noise, and a start
    // presented in the DONE cycle must be ignored.
    cyc(3'd4, 4'h0, 1'b0, 1'b1, 3'd3);
    cyc(3'd1, 4'hA, 1'b1, 1'b1, 3'd7);
    cyc(3'd7, 4'h5, 1'b0, 1'b0, 3'd2);
    cyc(3'd6, 4'h3, 1'b1, 1'b1, 3'd1);
    chk_eq("tp_rol_A",    32'(A),       32'b1101);
    chk_eq("tp_rol_so",   32'(ser_out), 32'h1);
    chk_eq("tp_rol_done", 32'(done),    32'h1);
    cyc(3'd2, 4'h0, 1'b1, 1'b1, 3'd2);
    cyc(3'd0, 4'h0, 1'b0, 1'b0, 3'd0);

    // Increment wrap.
    cyc(3'd1, 4'hF, 1'b0, 1'b0, 3'd0);
    cyc(3'd6, 4'h0, 1'b0, 1'b0, 3'd0);
    chk_eq("tp_wrap_c", 32'(carry), 32'h1);
    cyc(3'd6, 4'h0, 1'b0, 1'b0, 3'd0);
    chk_eq("tp_inc_A", 32'(A), 32'h1);

    // Serial shifts.
    cyc(3'd1, 4'b0010, 1'b0, 1'b0, 3'd0);
    cyc(3'd3, 4'h0, 1'b1, 1'b0, 3'd0);
    chk_eq("tp_shr_A", 32'(A), 32'b1001);
    cyc(3'd2, 4'h0, 1'b0, 1'b0, 3'd0);
    chk_eq("tp_shl_so", 32'(ser_out), 32'h1);

    // shamt=0 command and start with a non-shift mode.
    cyc(3'd2, 4'h0, 1'b1, 1'b1, 3'd0);
    chk_eq("tp_sh0_done", 32'(done), 32'h1);
    cyc(3'd0, 4'h0, 1'b0, 1'b0, 3'd0);
    cyc(3'd6, 4'h0, 1'b0, 1'b1, 3'd4);
    cyc(3'd0, 4'h0, 1'b0, 1'b0, 3'd0);

    // Commands longer than WIDTH.
    cyc(3'd1, 4'b1001, 1'b0, 1'b0, 3'd0);
    cyc(3'd5, 4'h0, 1'b0, 1'b1, 3'd7);
    for (int i = 0; i < 8; i++) cyc(3'd0, 4'h0, 1'b0, 1'b0, 3'd0);
    cyc(3'd2, 4'h0, 1'b0, 1'b1, 3'd7);
    for (int i = 0; i < 8; i++) cyc(3'd0, 4'h0, 1'(i), 1'b0, 3'd0);

    // Abort with reset after 2 of 5 SHR steps.
    cyc(3'd1, 4'b1110, 1'b0, 1'b0, 3'd0);
    cyc(3'd3, 4'h0, 1'b1, 1'b1, 3'd5);
    cyc(3'd0, 4'h0, 1'b1, 1'b0, 3'd0);
    cyc(3'd0, 4'h0, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_eq("abort_A",    32'(A),    32'h0);
    chk_eq("abort_busy", 32'(busy), 32'h0);
    chk_eq("abort_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    chk_eq("abort_nodone", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3'd1, 4'b0110, 1'b0, 1'b0, 3'd0);
    chk_eq("abort_load", 32'(A), 32'b0110);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
